// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: one request per handshake, one-cycle registered response.
// Define IMEM_BOUNDS_CHECK_EN to flag misaligned or out-of-range fetches through rsp_fault.
module imem_fetch_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          DEPTH     = 4096,
    parameter int          AW        = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_instr,
    output logic [31:0]   rsp_addr,
    output logic          rsp_fault,
    input  logic          load_en,
    input  logic [AW-1:0] load_idx,
    input  logic [31:0]   load_data,
    output logic [31:0]   fetch_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          acc;
    logic          fault;
    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic [31:0]   mem [DEPTH];

    assign offset = req_addr - BASE_ADDR;
    assign idx    = offset[AW+1:2];

`ifdef IMEM_BOUNDS_CHECK_EN
    assign fault = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                   ((offset >> 2) >= 32'(DEPTH));
`else
    // Without bounds checking the low address bits and the upper offset bits are don't-care.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{offset[1:0], offset[31:AW+2]};
    assign fault              = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        req_ready = (state == EMPTY) || rsp_ready;
        acc       = req_valid && req_ready;
        case (state)
            EMPTY:   if (acc) state_nxt = FULL;
            FULL:    if (rsp_ready && !acc) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    assign rsp_valid = (state == FULL);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= EMPTY;
            rsp_instr <= '0;
            rsp_addr  <= BASE_ADDR;
            rsp_fault <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (acc) begin
                rsp_addr  <= req_addr;
                rsp_fault <= fault;
                rsp_instr <= fault ? 32'h0000_0000 : mem[idx];
            end
            if (rsp_valid && rsp_ready) fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    // NOTE: the program store is deliberately left out of reset so it survives a CPU reset and maps to RAM.
    always_ff @(posedge clk) begin
        if (load_en) mem[load_idx] <= load_data;
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Randomized self-checking bench for imem_fetch_responder against a transaction-level model.
// Build with IMEM_BOUNDS_CHECK_EN defined to exercise the fault path.
module tb_imem_fetch_responder;

    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam int          DEPTH = 4096;
    localparam int          AW    = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_addr = BASE;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_instr;
    logic [31:0]   rsp_addr;
    logic          rsp_fault;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_idx = '0;
    logic [31:0]   load_data = '0;
    logic [31:0]   fetch_cnt;

    int checks   = 0;
    int failures = 0;

    imem_fetch_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_fault (rsp_fault),
        .load_en   (load_en),
        .load_idx  (load_idx),
        .load_data (load_data),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: program image plus the one response the consumer is currently offered.
    logic [31:0] model_mem [DEPTH];
    logic        exp_valid = 1'b0;
    logic [31:0] exp_addr  = BASE;
    logic [31:0] exp_instr = '0;
    logic        exp_fault = 1'b0;
    logic [31:0] exp_cnt   = '0;
    logic        take;
    logic        flt;

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] d;
        d = a - BASE;
        return int'((d / 4) % DEPTH);
    endfunction

    function automatic logic is_fault(input logic [31:0] a);
`ifdef IMEM_BOUNDS_CHECK_EN
        logic [31:0] d;
        d = a - BASE;
        return (a % 4 != 0) || (a < BASE) || (d / 4 >= DEPTH);
`else
        return (a === 32'hxxxx_xxxx);
`endif
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_valid = 1'b0;
            exp_addr  = BASE;
            exp_instr = '0;
            exp_fault = 1'b0;
            exp_cnt   = '0;
        end else begin
            take = req_valid && (!exp_valid || rsp_ready);
            if (exp_valid && rsp_ready) exp_cnt = exp_cnt + 1;
            if (take) begin
                flt       = is_fault(req_addr);
                exp_valid = 1'b1;
                exp_addr  = req_addr;
                exp_fault = flt;
                exp_instr = flt ? 32'h0 : model_mem[word_of(req_addr)];
            end else if (rsp_ready) begin
                exp_valid = 1'b0;
            end
            if (load_en) model_mem[load_idx] = load_data;
        end
    end

    always @(negedge clk) begin
        check("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_valid});
        check("req_ready", {31'b0, req_ready}, {31'b0, (!exp_valid || rsp_ready)});
        check("fetch_cnt", fetch_cnt, exp_cnt);
        if (exp_valid || !reset) begin
            check("rsp_addr", rsp_addr, exp_addr);
            check("rsp_instr", rsp_instr, exp_instr);
            check("rsp_fault", {31'b0, rsp_fault}, {31'b0, exp_fault});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_one(input logic [31:0] a);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = a;
        cyc();
        req_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        int unsigned w;
        r = $urandom_range(0, 9);
        w = $urandom_range(0, DEPTH - 1);
        if (r < 7)       return BASE + 32'(4 * w);
        else if (r == 7) return BASE + 32'(4 * w) + 32'($urandom_range(1, 3));
        else if (r == 8) return BASE - 32'(4 * $urandom_range(1, 16));
        else             return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 64));
    endfunction

    logic [31:0] snap;

    initial begin
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();

        // Program image: a few pinned words, everything else random.
        for (int i = 0; i < DEPTH; i++) begin
            load_en   = 1'b1;
            load_idx  = AW'(i);
            load_data = (i == 0) ? 32'h3C01_0001 :
                        (i == 1) ? 32'h3421_0002 :
                        (i == 2) ? 32'hDEAD_BEEF :
                        (i == 3) ? 32'hCAFE_F00D :
                        (i == 5) ? 32'h1111_1111 : $urandom;
            cyc();
        end
        load_en = 1'b0;

        // Back-to-back fetches.
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_3000;
        cyc();
        check("t1_valid", {31'b0, rsp_valid}, 32'd1);
        check("t1_instr0", rsp_instr, 32'h3C01_0001);
        check("t1_addr0", rsp_addr, 32'h0000_3000);
        req_addr = 32'h0000_3004;
        cyc();
        check("t1_instr1", rsp_instr, 32'h3421_0002);
        check("t1_addr1", rsp_addr, 32'h0000_3004);
        req_valid = 1'b0;
        cyc();
        check("t1_cnt", fetch_cnt, 32'd2);

        // Stall holds the response and blocks new requests.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0000_3008;
        cyc();
        req_addr = 32'h0000_300C;
        for (int k = 0; k < 3; k++) begin
            #0 check("t2_ready", {31'b0, req_ready}, 32'd0);
            cyc();
            check("t2_instr", rsp_instr, 32'hDEAD_BEEF);
            check("t2_addr", rsp_addr, 32'h0000_3008);
            check("t2_cnt", fetch_cnt, 32'd2);
        end
        rsp_ready = 1'b1;
        #0 check("t2_ready_up", {31'b0, req_ready}, 32'd1);
        cyc();
        check("t2_next_instr", rsp_instr, 32'hCAFE_F00D);
        check("t2_next_addr", rsp_addr, 32'h0000_300C);
        check("t2_next_cnt", fetch_cnt, 32'd3);
        req_valid = 1'b0;
        cyc();

        // Load and fetch of the same word in one cycle: old word first, new word after.
        load_en   = 1'b1;
        load_idx  = AW'(5);
        load_data = 32'hAAAA_0000;
        fetch_one(32'h0000_3014);
        load_en = 1'b0;
        check("t3_old", rsp_instr, 32'h1111_1111);
        fetch_one(32'h0000_3014);
        check("t3_new", rsp_instr, 32'hAAAA_0000);

`ifdef IMEM_BOUNDS_CHECK_EN
        fetch_one(32'h0000_3002);
        check("t4_misalign_fault", {31'b0, rsp_fault}, 32'd1);
        check("t4_misalign_instr", rsp_instr, 32'd0);
        fetch_one(32'h0000_2FFC);
        check("t4_below_fault", {31'b0, rsp_fault}, 32'd1);
        fetch_one(32'h0000_3000 + 32'(4 * DEPTH));
        check("t4_above_fault", {31'b0, rsp_fault}, 32'd1);
        check("t4_above_instr", rsp_instr, 32'd0);
`else
        fetch_one(32'h0000_3000 + 32'(4 * DEPTH));
        check("t5_wrap_instr", rsp_instr, 32'h3C01_0001);
        check("t5_wrap_fault", {31'b0, rsp_fault}, 32'd0);
`endif

        // Randomized traffic, including loads aimed at the word being fetched.
        for (int n = 0; n < 3000; n++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            req_addr  = rand_addr();
            load_en   = ($urandom_range(0, 3) == 0);
            load_idx  = ($urandom_range(0, 1) == 0) ? AW'(word_of(req_addr)) : AW'($urandom);
            load_data = $urandom;
            cyc();
        end
        load_en   = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        cyc();

        // Reset while a stalled response is held.
        snap      = model_mem[5];
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0000_3004;
        cyc();
        check("t6_held", {31'b0, rsp_valid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_valid", {31'b0, rsp_valid}, 32'd0);
        check("t6_addr", rsp_addr, 32'h0000_3000);
        check("t6_instr", rsp_instr, 32'd0);
        check("t6_cnt", fetch_cnt, 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        fetch_one(32'h0000_3014);
        check("t6_mem_kept", rsp_instr, snap);
        check("t6_cnt_after", fetch_cnt, 32'd0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
Instruction-memory responder that answers the fetch addresses issued by the PC register. It accepts one word-address request per handshake and returns the 32-bit instruction one cycle later through a registered valid/ready response stage. A separate write port preloads program words during boot or test. It sits between PC/NPC and the decode stage of the CPU.

Parameters:
BASE_ADDR, 32'h00003000, byte address of instruction word 0; equals the PC reset value.
DEPTH, 4096, number of 32-bit words; must be a power of two.
AW, 12, index width; equals log2(DEPTH).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
req_valid  input  1  fetch request present.
req_ready  output  1  responder can accept a request this cycle.
req_addr  input  32  byte address of the instruction, normally PC output.
rsp_valid  output  1  response register holds a valid instruction.
rsp_ready  input  1  consumer takes the response this cycle.
rsp_instr  output  32  fetched instruction word.
rsp_addr  output  32  address the response belongs to.
rsp_fault  output  1  request was misaligned or out of range (feature-dependent).
load_en  input  1  write one program word this cycle.
load_idx  input  AW  word index to write.
load_data  input  32  word to write.
fetch_cnt  output  32  count of completed response handshakes.

Behaviour:
- Reset (reset low, asynchronous): rsp_valid=0, rsp_instr=0, rsp_addr=BASE_ADDR, rsp_fault=0, fetch_cnt=0. Memory contents are not cleared. Deassertion is sampled at the next clk edge.
- Accept condition: acc = req_valid & req_ready.
- req_ready = ~rsp_valid | rsp_ready. This is combinational, so back-to-back fetches run at 1 per cycle.
- Index: idx = (req_addr - BASE_ADDR) >> 2, truncated to AW bits.
- Latency is exactly 1 cycle. On the edge where acc=1, the response register is loaded:
  - rsp_valid=1
  - rsp_addr=req_addr
  - rsp_instr=mem[idx], or 0 (NOP) if faulted
  - rsp_fault per the fault rule
- Response states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - EMPTY→FULL on acc.
  - FULL→FULL on acc with rsp_ready; the new word replaces the old one.
  - FULL→EMPTY on rsp_ready without acc.
  - FULL stays unchanged on ~rsp_ready.
- Stall: while rsp_valid & ~rsp_ready, rsp_instr, rsp_addr and rsp_fault hold stable and req_ready=0.
- fetch_cnt increments by 1 on each rsp_valid & rsp_ready edge and wraps 32'hFFFFFFFF→0.
- Load port: on load_en, mem[load_idx] <= load_data. Loads are independent of the fetch handshake.
- Load/read collision at the same idx in the same cycle is read-before-write: the response carries the old word, and the next fetch sees the new word.
- Reset asserted mid-operation drops any held response immediately. An in-flight accept on that edge is discarded.

Optional Feature:
Macro IMEM_BOUNDS_CHECK_EN.
- Defined: rsp_fault=1 when req_addr[1:0]!=0, or req_addr<BASE_ADDR, or (req_addr-BASE_ADDR)>>2 >= DEPTH. A faulted response has rsp_instr=32'h00000000, and memory is not read for it. Faulted responses still complete the handshake and count in fetch_cnt.
- Undefined: rsp_fault is tied to 0, req_addr[1:0] is ignored, and idx wraps modulo DEPTH (e.g. BASE_ADDR+4*DEPTH reads word 0).

Test Plan:
1. Load mem[0]=32'h3C010001 and mem[1]=32'h34210002. Reset low→high. Request 0x3000 then 0x3004 on consecutive cycles with rsp_ready=1 → rsp_valid high from the cycle after the first accept, words returned in order with rsp_addr 0x3000 then 0x3004, fetch_cnt=2.
2. Stall: hold rsp_ready=0 for 3 cycles with req_valid=1 → req_ready=0, rsp_instr/rsp_addr held constant, fetch_cnt unchanged. Raise rsp_ready → next word is accepted on that same edge.
3. Collision: in the same cycle, load_idx=5 with load_data=32'hAAAA0000 and fetch 0x3014 while mem[5]=32'h11111111 → response is 32'h11111111. Refetching 0x3014 → 32'hAAAA0000.
4. With IMEM_BOUNDS_CHECK_EN: request 0x3002 → rsp_fault=1, rsp_instr=0. Request 0x2FFC → fault. Request 0x3000+4*4096 → fault.
5. Without the macro: request 0x3000+4*4096 → returns mem[0], rsp_fault=0.
6. Reset low while rsp_valid=1 and rsp_ready=0 → rsp_valid=0 and rsp_addr=0x3000 before the next clk edge. fetch_cnt=0 and memory contents are preserved.
